// File: rtl/codec_pkg.sv
// codec_pkg: shared types and default sizing for the codec frame controller.
// FSM state encoding, default frame geometry and a saturating increment helper.
package codec_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DATA,
      ST_TAIL,
      ST_DRAIN,
      ST_DONE
   } state_t;

   localparam int unsigned FRAME_LEN_DEF = 128;
   localparam int unsigned TAIL_LEN_DEF  = 6;
   localparam int unsigned DEC_DELAY_DEF = 29;

   // 16-bit counters stick at all-ones instead of wrapping
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/codec_ref_delay.sv
// codec_ref_delay: enabled shift register holding the reference data bits.
// dout is the bit that entered DEPTH enabled cycles ago, so it lines up with
// the decoder output for the same data bit.
module codec_ref_delay #(
   parameter int unsigned DEPTH = 29
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] sr;

   // shift only on enabled cycles; stalls freeze the alignment with the decoder
   always_ff @(posedge clk) begin
      if (reset) begin
         sr <= '0;
      end else if (en) begin
         for (int i = DEPTH - 1; i > 0; i--) sr[i] <= sr[i-1];
         sr[0] <= din;
      end
   end

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/codec_frame_ctrl.sv
// codec_frame_ctrl: frames a bit stream through a convolutional encoder and
// Viterbi decoder pair, appends the zero tail, waits out the decoder latency
// and optionally counts decode errors against a delayed copy of the data.
// Optional feature macro: CODEC_FRAME_BER_EN (reference delay line + compare,
// err_count live). Without it err_count is tied to zero; FSM timing unchanged.
module codec_frame_ctrl
   import codec_pkg::*;
#(
   parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
   parameter int unsigned TAIL_LEN  = TAIL_LEN_DEF,
   parameter int unsigned DEC_DELAY = DEC_DELAY_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic        src_valid,
   input  logic        src_bit,
   output logic        src_ready,
   output logic        enc_en,
   output logic        enc_bit,
   input  logic        dec_bit,
   input  logic        dec_valid,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] bit_count,
   output logic [15:0] err_count
);

   // n values on the last enabled cycle of each phase
   localparam logic [31:0] DATA_END  = 32'(FRAME_LEN - 1);
   localparam logic [31:0] TAIL_END  = 32'(FRAME_LEN + TAIL_LEN - 1);
   localparam logic [31:0] DRAIN_END = 32'(FRAME_LEN + DEC_DELAY - 1);

   // zero-length phases are skipped rather than spending a dead cycle in them
   localparam state_t AFTER_TAIL = (DEC_DELAY > TAIL_LEN) ? ST_DRAIN : ST_DONE;
   localparam state_t AFTER_DATA = (TAIL_LEN > 0) ? ST_TAIL : AFTER_TAIL;

   state_t      state, state_nxt;
   logic [31:0] n;           // enabled-cycle index within the frame
   logic        advance;     // an enabled cycle that is not being aborted

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // next state and combinational datapath controls
   always_comb begin
      state_nxt  = state;
      src_ready  = 1'b0;
      enc_en     = 1'b0;
      enc_bit    = 1'b0;
      busy       = (state != ST_IDLE);
      frame_done = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            src_ready = 1'b1;
            enc_en    = src_valid;
            enc_bit   = src_bit;
            if (src_valid && n == DATA_END) state_nxt = AFTER_DATA;
         end
         ST_TAIL: begin
            enc_en = 1'b1;
            if (n == TAIL_END) state_nxt = AFTER_TAIL;
         end
         ST_DRAIN: begin
            enc_en = 1'b1;
            if (n == DRAIN_END) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            frame_done = 1'b1;
            state_nxt  = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      // abort beats everything else, including a start arriving the same cycle
      if (abort && state != ST_IDLE) state_nxt = ST_IDLE;
   end

   // an aborted cycle leaves every counter where it was
   assign advance = enc_en && !abort;

   // frame position and accepted-bit counter
   always_ff @(posedge clk) begin
      if (reset) begin
         n         <= '0;
         bit_count <= '0;
      end else if (state == ST_IDLE && start) begin
         n         <= '0;
         bit_count <= '0;
      end else if (advance) begin
         n <= n + 32'd1;
         if (state == ST_DATA) bit_count <= sat_inc16(bit_count);
      end
   end

`ifdef CODEC_FRAME_BER_EN
   logic ref_bit;
   logic slot;

   codec_ref_delay #(.DEPTH(DEC_DELAY)) u_ref_delay (
      .clk   (clk),
      .reset (reset),
      .en    (enc_en),
      .din   (enc_bit),
      .dout  (ref_bit)
   );

   // a slot is an enabled cycle whose decoder output belongs to a data bit
   assign slot = advance && (n >= 32'(DEC_DELAY)) && (n < 32'(FRAME_LEN + DEC_DELAY));

   // error counter: wrong bit or missing decode_valid both count
   always_ff @(posedge clk) begin
      if (reset) begin
         err_count <= '0;
      end else if (state == ST_IDLE && start) begin
         err_count <= '0;
      end else if (slot && (!dec_valid || dec_bit != ref_bit)) begin
         err_count <= sat_inc16(err_count);
      end
   end
`else
   logic unused_dec;

   assign unused_dec = &{1'b0, dec_bit, dec_valid};
   assign err_count  = '0;
`endif

endmodule

// File: doc/codec_frame_ctrl.md
CODEC_FRAME_CTRL -- requirements
Module: codec_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 128, data bits per frame (1..65535).
REQ-002 SHALL have parameter TAIL_LEN, default 6, zero flush bits (K-1) appended after data.
REQ-003 SHALL have parameter DEC_DELAY, default 29, decoder latency in enabled cycles; DEC_DELAY >= TAIL_LEN.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle frame start request.
REQ-007 SHALL have port abort  input  1  terminate current frame.
REQ-008 SHALL have port src_valid  input  1  upstream bit available.
REQ-009 SHALL have port src_bit  input  1  upstream data bit.
REQ-010 SHALL have port src_ready  output  1  bit accepted this cycle when src_valid is also high.
REQ-011 SHALL have port enc_en  output  1  shared enable, drives encoder encode_en and decoder enb.
REQ-012 SHALL have port enc_bit  output  1  drives encoder audio_in.
REQ-013 SHALL have port dec_bit  input  1  decoder decoded output.
REQ-014 SHALL have port dec_valid  input  1  decoder decode_valid.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port frame_done  output  1  one-cycle completion pulse.
REQ-017 SHALL have port bit_count  output  16  data bits accepted in current/last frame.
REQ-018 SHALL have port err_count  output  16  decode mismatches in current/last frame.

Function
REQ-019 SHALL implement FSM IDLE -> DATA -> TAIL -> DRAIN -> DONE -> IDLE.
REQ-020 IDLE: on start, clear bit_count, err_count and enabled-cycle counter n, go to DATA.
REQ-021 DATA: src_ready=1; enc_en=src_valid; enc_bit=src_bit; go to TAIL after FRAME_LEN-th accept.
REQ-022 src_ready, enc_en and enc_bit SHALL be combinational from state and src_valid: zero-cycle latency.
REQ-023 src_valid low in DATA SHALL stall the frame: enc_en=0 and all counters hold.
REQ-024 TAIL: enc_en=1, enc_bit=0 for exactly TAIL_LEN cycles.
REQ-025 DRAIN: enc_en=1, enc_bit=0; SHALL exit when n reaches FRAME_LEN+DEC_DELAY, i.e. after DEC_DELAY-TAIL_LEN cycles.
REQ-026 DONE: frame_done=1 and enc_en=0 for one cycle, then IDLE; counts hold until the next start.
REQ-027 n SHALL count enc_en cycles only, starting at 0 on the first accepted data bit.
REQ-028 Compare slot: enc_en=1 and DEC_DELAY <= n < FRAME_LEN+DEC_DELAY; compares dec_bit against data bit n-DEC_DELAY.
REQ-029 Mismatch, or dec_valid=0 in a slot, SHALL increment err_count; err_count and bit_count saturate at 16'hFFFF.
REQ-030 start while busy SHALL be ignored.
REQ-031 abort in any non-IDLE state SHALL go to IDLE next cycle with no frame_done; counts hold; abort has priority over start.
REQ-032 Outside DATA, TAIL and DRAIN: src_ready=0, enc_en=0, enc_bit=0.

Reset
REQ-033 reset SHALL force IDLE, n=0, bit_count=0, err_count=0, frame_done=0, busy=0, src_ready=0, enc_en=0, enc_bit=0, and clear the delay line.
REQ-034 reset SHALL override start and abort in the same cycle.

Configuration
REQ-035 Macro CODEC_FRAME_BER_EN defined: DEC_DELAY-deep reference delay line (advances on enc_en) plus compare logic; err_count live.
REQ-036 Macro undefined: no delay line or compare logic; err_count tied 0; FSM timing and frame_done identical.

Structure
REQ-037 Package codec_pkg SHALL hold the FSM state enum and the default FRAME_LEN/TAIL_LEN/DEC_DELAY constants.
REQ-038 Sub-module codec_ref_delay SHALL hold the enabled shift register (depth DEC_DELAY).

Verification
REQ-039 Loopback through convolutional_encoder + Viterbi_Decoder1; FRAME_LEN=128; src_valid held high -> frame_done 158 cycles after start accept, err_count=0, bit_count=128.
REQ-040 Loopback; dec_bit inverted in compare slots 3 and 10 -> err_count=2.
REQ-041 src_valid low 5 cycles at data bit 50 -> enc_en low exactly those 5 cycles, frame_done 5 cycles later, err_count=0.
REQ-042 dec_valid held 0 throughout -> err_count=128.
REQ-043 abort at data bit 40 -> IDLE next cycle, busy=0, no frame_done; next start completes a full frame with err_count=0.
REQ-044 start pulsed in DRAIN ignored; reset asserted in DRAIN -> all outputs at reset values next cycle.
